// File: rtl/fnv_digest_stream_if.sv
// Byte-stream handshake bundle for the FNV-1a digest engine.
// Master drives message bytes and reads the digest back; slave is the engine.
interface fnv_digest_stream_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        abort;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] digest;
  logic        digest_valid;
  logic [15:0] byte_count;

  modport master (
    output in_byte, in_valid, in_last, abort, out_ready,
    input  in_ready, out_byte, out_valid, digest, digest_valid, byte_count
  );

  modport slave (
    input  in_byte, in_valid, in_last, abort, out_ready,
    output in_ready, out_byte, out_valid, digest, digest_valid, byte_count
  );
endinterface

// File: rtl/fnv_digest_stream.sv
// FNV-1a 32-bit digest engine: folds one byte per cycle, then serializes
// the latched digest as four bytes on the TX side.
module fnv_digest_stream #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
  parameter logic [31:0] FNV_PRIME    = 32'h01000193,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  fnv_digest_stream_if.slave bus
);

  typedef enum logic {ACCEPT, DRAIN} state_e;

  state_e      state_q;
  logic [31:0] hash_q;
  logic [31:0] hash_d;
  logic [31:0] digest_q;
  logic        digest_valid_q;
  logic [15:0] count_q;
  logic [1:0]  idx_q;
  logic [1:0]  lane;
  logic        accept;

  assign accept = (state_q == ACCEPT) && bus.in_valid;
  assign hash_d = (hash_q ^ {24'b0, bus.in_byte}) * FNV_PRIME;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ACCEPT;
      hash_q         <= OFFSET_BASIS;
      digest_q       <= 32'h0;
      digest_valid_q <= 1'b0;
      count_q        <= 16'h0;
      idx_q          <= 2'd0;
    end else if (bus.abort) begin
      state_q <= ACCEPT;
      hash_q  <= OFFSET_BASIS;
      count_q <= 16'h0;
      idx_q   <= 2'd0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (accept) begin
            hash_q <= hash_d;
            // A set digest_valid means this is the first byte of a new message.
            if (digest_valid_q) begin
              count_q        <= 16'd1;
              digest_valid_q <= 1'b0;
            end else if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
            if (bus.in_last) begin
              digest_q       <= hash_d;
              digest_valid_q <= 1'b1;
              idx_q          <= 2'd0;
              state_q        <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              hash_q  <= OFFSET_BASIS;
              state_q <= ACCEPT;
            end
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  // Outputs decode only registered state, so nothing on in_* reaches out_*.
  assign lane             = MSB_FIRST ? ~idx_q : idx_q;
  assign bus.in_ready     = (state_q == ACCEPT);
  assign bus.out_valid    = (state_q == DRAIN);
  assign bus.out_byte     = (state_q == DRAIN) ? digest_q[{lane, 3'b000} +: 8] : 8'h00;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.byte_count   = count_q;

endmodule

// File: tb/tb_fnv_digest_stream.sv
// Scoreboard bench: an MSB-first and an LSB-first engine see identical stimulus;
// monitors pop expected digest bytes whenever a TX transfer is presented.
module tb_fnv_digest_stream;

  localparam logic [31:0] OB    = 32'h811C9DC5;
  localparam logic [31:0] PRIME = 32'h01000193;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] expM[$];
  logic [7:0] expL[$];

  always #5 clk = ~clk;

  fnv_digest_stream_if bm();
  fnv_digest_stream_if bl();

  fnv_digest_stream #(.MSB_FIRST(1'b1)) dutM (.clk(clk), .reset(reset), .bus(bm.slave));
  fnv_digest_stream #(.MSB_FIRST(1'b0)) dutL (.clk(clk), .reset(reset), .bus(bl.slave));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference FNV-1a straight from its definition: xor the byte in, multiply mod 2^32.
  function automatic logic [31:0] fnvRef(input logic [7:0] msg[$]);
    int unsigned h = OB;
    foreach (msg[i]) h = (h ^ int'(msg[i])) * PRIME;
    return h;
  endfunction

  task automatic drive(input logic [7:0] b, input logic v, input logic l, input logic a);
    bm.in_byte = b; bm.in_valid = v; bm.in_last = l; bm.abort = a;
    bl.in_byte = b; bl.in_valid = v; bl.in_last = l; bl.abort = a;
  endtask

  task automatic setReady(input logic r);
    bm.out_ready = r;
    bl.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && bm.out_valid && bm.out_ready) begin
      if (expM.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected MSB out_byte: got %h, expected none", bm.out_byte);
      end else checkOutput("MSB out_byte", {24'b0, bm.out_byte}, {24'b0, expM.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!reset && bl.out_valid && bl.out_ready) begin
      if (expL.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected LSB out_byte: got %h, expected none", bl.out_byte);
      end else checkOutput("LSB out_byte", {24'b0, bl.out_byte}, {24'b0, expL.pop_front()});
    end
  end

  // Sends one message (optionally with idle gaps carrying a stray in_last) and
  // returns just after the posedge that accepts the final byte.
  task automatic applyStimulus(input logic [7:0] msg[$], input bit gaps);
    logic [31:0] h;
    int i = 0;
    h = fnvRef(msg);
    while (i < msg.size()) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        drive(8'($urandom), 1'b0, 1'($urandom), 1'b0);
      end else begin
        drive(msg[i], 1'b1, (i == msg.size() - 1), 1'b0);
        if (i == msg.size() - 1) begin
          for (int k = 3; k >= 0; k--) expM.push_back(h[k*8 +: 8]);
          for (int k = 0; k < 4; k++)  expL.push_back(h[k*8 +: 8]);
        end
        i++;
      end
      @(negedge clk);
      checkOutput("in_ready while sending", {31'b0, bm.in_ready}, 32'd1);
      tick();
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drainWait(input bit randomReady);
    int n = 0;
    while (!bm.in_ready && n < 200) begin
      setReady(randomReady ? 1'($urandom) : 1'b1);
      tick();
      n++;
    end
    setReady(1'b1);
    if (n >= 200) begin
      tests++; fails++;
      $display("[TB] FAIL drain timeout: got in_ready %b, expected 1", bm.in_ready);
    end
    checkOutput("MSB bytes left", expM.size(), 32'd0);
    checkOutput("LSB bytes left", expL.size(), 32'd0);
  endtask

  task automatic runMessage(input logic [7:0] msg[$], input bit gaps, input bit randomReady);
    applyStimulus(msg, gaps);
    @(negedge clk);
    checkOutput("digest", bm.digest, fnvRef(msg));
    checkOutput("LSB digest", bl.digest, fnvRef(msg));
    checkOutput("digest_valid", {31'b0, bm.digest_valid}, 32'd1);
    checkOutput("byte_count", {16'b0, bm.byte_count}, msg.size());
    checkOutput("in_ready in drain", {31'b0, bm.in_ready}, 32'd0);
    checkOutput("out_valid in drain", {31'b0, bm.out_valid}, 32'd1);
    drainWait(randomReady);
    checkOutput("byte_count held", {16'b0, bm.byte_count}, msg.size());
  endtask

  task automatic checkResetState();
    checkOutput("reset in_ready", {31'b0, bm.in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'b0, bm.out_valid}, 32'd0);
    checkOutput("reset out_byte", {24'b0, bm.out_byte}, 32'd0);
    checkOutput("reset digest", bm.digest, 32'd0);
    checkOutput("reset digest_valid", {31'b0, bm.digest_valid}, 32'd0);
    checkOutput("reset byte_count", {16'b0, bm.byte_count}, 32'd0);
    checkOutput("reset LSB out_valid", {31'b0, bl.out_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] msg[$];
    reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    setReady(1'b1);
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    checkResetState();
    tick();

    msg = '{8'h61};
    runMessage(msg, 1'b0, 1'b0);
    checkOutput("digest of a", bm.digest, 32'hE40C292C);

    msg = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
    runMessage(msg, 1'b0, 1'b0);
    checkOutput("digest of foobar", bm.digest, 32'hBF9CF968);
    msg = '{8'h66, 8'h6F, 8'h6F};
    runMessage(msg, 1'b0, 1'b0);
    checkOutput("digest of foo", bm.digest, 32'hA9F37ED7);

    // TX backpressure holds the first digest byte.
    setReady(1'b0);
    msg = '{8'h61};
    applyStimulus(msg, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stalled MSB out_byte", {24'b0, bm.out_byte}, 32'hE4);
      checkOutput("stalled LSB out_byte", {24'b0, bl.out_byte}, 32'h2C);
      checkOutput("stalled in_ready", {31'b0, bm.in_ready}, 32'd0);
      tick();
    end
    drainWait(1'b0);

    // Abort mid-message discards the partial hash.
    drive(8'h66, 1'b1, 1'b0, 1'b0); tick();
    drive(8'h6F, 1'b1, 1'b0, 1'b0); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort byte_count", {16'b0, bm.byte_count}, 32'd0);
    checkOutput("abort digest_valid", {31'b0, bm.digest_valid}, 32'd0);
    checkOutput("abort in_ready", {31'b0, bm.in_ready}, 32'd1);
    tick();
    msg = '{8'h61};
    runMessage(msg, 1'b0, 1'b0);
    checkOutput("digest after abort", bm.digest, 32'hE40C292C);

    // Abort during drain after two bytes have transferred.
    setReady(1'b0);
    applyStimulus(msg, 1'b0);
    setReady(1'b1);
    tick(); tick();
    setReady(1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("MSB bytes left at abort", expM.size(), 32'd2);
    expM.delete(); expL.delete();
    @(negedge clk);
    checkOutput("drain abort out_valid", {31'b0, bm.out_valid}, 32'd0);
    checkOutput("drain abort digest", bm.digest, 32'hE40C292C);
    checkOutput("drain abort digest_valid", {31'b0, bm.digest_valid}, 32'd1);
    checkOutput("drain abort byte_count", {16'b0, bm.byte_count}, 32'd0);
    checkOutput("drain abort in_ready", {31'b0, bm.in_ready}, 32'd1);
    tick();
    setReady(1'b1);

    // Randomised messages with idle gaps and random TX readiness.
    for (int m = 0; m < 10; m++) begin
      int len = $urandom_range(1, 12);
      msg.delete();
      for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
      runMessage(msg, 1'b1, 1'b1);
    end

    // Reset while the digest is draining.
    setReady(1'b0);
    msg = '{8'h62};
    applyStimulus(msg, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expM.delete(); expL.delete();
    setReady(1'b1);
    @(negedge clk);
    checkResetState();
    tick();
    msg = '{8'h66, 8'h6F, 8'h6F};
    runMessage(msg, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
